vadd_rr_sched: RTL and testbench

VADD_RR_SCHED -- requirements
Module: vadd_rr_sched

---
 rtl/vadd_sched_pkg.sv | 23 ++
 rtl/vadd_tag_fifo.sv | 46 ++++
 rtl/vadd_rr_sched.sv | 155 +++++++++++++++
 tb/tb_vadd_rr_sched.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vadd_sched_pkg.sv
// Shared types and helpers for the vector-add round-robin scheduler.
// Holds the scheduler state encoding and the tag-width helper used to size
// requester indices and tag FIFO entries.
package vadd_sched_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } sched_state_t;

  localparam int PERF_W = 32;

  // Width of a requester index; never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vadd_tag_fifo.sv
// Purpose: synchronous FIFO holding requester tags of beats in flight in the adder.
// Latency: a pushed tag is visible at pop_dat one cycle after the push (no bypass).
// Backpressure: full/empty flags only; push while full and pop while empty are ignored.
// Ports: aclk/aresetn clock and async active-low reset; push/push_dat write side;
//        pop/pop_dat read side (pop_dat is the current head); full/empty flags.
module vadd_tag_fifo #(
  parameter int C_WIDTH = 2,
  parameter int C_DEPTH = 8   // power of 2, at least 2
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               push,
  input  logic [C_WIDTH-1:0] push_dat,
  input  logic               pop,
  output logic [C_WIDTH-1:0] pop_dat,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(C_DEPTH);

  logic [C_WIDTH-1:0] mem [C_DEPTH];
  // One extra wrap bit distinguishes full from empty when the indices match.
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset: only entries between the pointers are ever read.
  always_ff @(posedge aclk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/vadd_rr_sched.sv
// Purpose: round-robin packet arbiter feeding a shared vector adder, routing results back by tag.
// Latency: one arbitration cycle in IDLE before the first beat; results routed combinationally.
// Backpressure: a_tready/tag-full stall the granted requester; m_tready of the head tag stalls r_tready.
// Ports: aclk, aresetn (async active-low); s_* per-requester operand streams;
//        a_* operand stream to the adder; r_* adder result stream; m_* per-requester
//        result streams (shared m_tdata); busy = packet granted or beats in flight.
//        Optional macro VADD_SCHED_PERF_EN adds perf_beats (32-bit saturating
//        accepted-beat count per requester).
module vadd_rr_sched
  import vadd_sched_pkg::*;
#(
  parameter int C_DATA_WIDTH   = 32,
  parameter int C_NUM_CHANNELS = 2,
  parameter int C_NUM_REQ      = 4,
  parameter int C_TAG_DEPTH    = 8
) (
  input  logic                                           aclk,
  input  logic                                           aresetn,
  input  logic [C_NUM_REQ-1:0]                           s_tvalid,
  input  logic [C_NUM_REQ*C_NUM_CHANNELS*C_DATA_WIDTH-1:0] s_tdata,
  input  logic [C_NUM_REQ-1:0]                           s_tlast,
  output logic [C_NUM_REQ-1:0]                           s_tready,
  output logic                                           a_tvalid,
  output logic [C_NUM_CHANNELS*C_DATA_WIDTH-1:0]         a_tdata,
  input  logic                                           a_tready,
  input  logic                                           r_tvalid,
  input  logic [C_DATA_WIDTH-1:0]                        r_tdata,
  output logic                                           r_tready,
  output logic [C_NUM_REQ-1:0]                           m_tvalid,
  output logic [C_DATA_WIDTH-1:0]                        m_tdata,
  input  logic [C_NUM_REQ-1:0]                           m_tready,
  output logic                                           busy
`ifdef VADD_SCHED_PERF_EN
  ,
  output logic [C_NUM_REQ*PERF_W-1:0]                    perf_beats
`endif
);

  localparam int TW = clog2(C_NUM_REQ);
  localparam int BW = C_NUM_CHANNELS * C_DATA_WIDTH;

  sched_state_t   state;
  logic [TW-1:0]  ptr;
  logic [TW-1:0]  gnt;
  logic [TW-1:0]  rr_pick;
  logic [BW-1:0]  s_slice [C_NUM_REQ];

  logic           tag_full;
  logic           tag_empty;
  logic [TW-1:0]  head;
  logic           in_grant;
  logic           beat_acc;
  logic           last_acc;
  logic           res_pop;

  for (genvar i = 0; i < C_NUM_REQ; i++) begin : g_slice
    assign s_slice[i] = s_tdata[i*BW +: BW];
  end

  // First valid requester at or after ptr, wrapping past the last requester.
  always_comb begin
    int   idx;
    logic found;
    rr_pick = ptr;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < C_NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= C_NUM_REQ) idx = idx - C_NUM_REQ;
      if (!found && s_tvalid[TW'(idx)]) begin
        found   = 1'b1;
        rr_pick = TW'(idx);
      end
    end
  end

  assign in_grant = (state == GRANT);
  assign a_tvalid = in_grant && s_tvalid[gnt] && !tag_full;
  assign a_tdata  = s_slice[gnt];
  assign beat_acc = a_tvalid && a_tready;
  assign last_acc = beat_acc && s_tlast[gnt];

  always_comb begin
    s_tready = '0;
    if (in_grant) s_tready[gnt] = a_tready && !tag_full;
  end

  // Grant is latched in IDLE and only released by the accepted last beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|s_tvalid) begin
            gnt   <= rr_pick;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (last_acc) begin
            ptr   <= (gnt == TW'(C_NUM_REQ - 1)) ? '0 : gnt + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  vadd_tag_fifo #(
    .C_WIDTH (TW),
    .C_DEPTH (C_TAG_DEPTH)
  ) u_tag_fifo (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .push     (beat_acc),
    .push_dat (gnt),
    .pop      (res_pop),
    .pop_dat  (head),
    .full     (tag_full),
    .empty    (tag_empty)
  );

  // A result with no outstanding tag is held off rather than dropped.
  always_comb begin
    m_tvalid = '0;
    r_tready = 1'b0;
    if (!tag_empty) begin
      m_tvalid[head] = r_tvalid;
      r_tready       = m_tready[head];
    end
  end

  assign m_tdata = r_tdata;
  assign res_pop = r_tvalid && r_tready;
  assign busy    = in_grant || !tag_empty;

`ifdef VADD_SCHED_PERF_EN
  for (genvar i = 0; i < C_NUM_REQ; i++) begin : g_perf
    logic [PERF_W-1:0] cnt;
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        cnt <= '0;
      end else if (beat_acc && (gnt == TW'(i)) && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
    end
    assign perf_beats[i*PERF_W +: PERF_W] = cnt;
  end
`endif

endmodule

// File: tb/tb_vadd_rr_sched.sv
// Directed bench for vadd_rr_sched: the bench plays requesters, the adder
// (lane sum, results released when r_en is set) and the result consumers.
module tb_vadd_rr_sched;

  localparam int N  = 4;
  localparam int CH = 2;
  localparam int W  = 32;
  localparam int D  = 8;

  logic                aclk;
  logic                aresetn;
  logic [N-1:0]        s_tvalid;
  logic [N*CH*W-1:0]   s_tdata;
  logic [N-1:0]        s_tlast;
  logic [N-1:0]        s_tready;
  logic                a_tvalid;
  logic [CH*W-1:0]     a_tdata;
  logic                a_tready;
  logic                r_tvalid;
  logic [W-1:0]        r_tdata;
  logic                r_tready;
  logic [N-1:0]        m_tvalid;
  logic [W-1:0]        m_tdata;
  logic [N-1:0]        m_tready;
  logic                busy;
`ifdef VADD_SCHED_PERF_EN
  logic [N*32-1:0]     perf_beats;
`endif

  vadd_rr_sched #(
    .C_DATA_WIDTH   (W),
    .C_NUM_CHANNELS (CH),
    .C_NUM_REQ      (N),
    .C_TAG_DEPTH    (D)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .s_tvalid (s_tvalid),
    .s_tdata  (s_tdata),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .a_tvalid (a_tvalid),
    .a_tdata  (a_tdata),
    .a_tready (a_tready),
    .r_tvalid (r_tvalid),
    .r_tdata  (r_tdata),
    .r_tready (r_tready),
    .m_tvalid (m_tvalid),
    .m_tdata  (m_tdata),
    .m_tready (m_tready),
    .busy     (busy)
`ifdef VADD_SCHED_PERF_EN
    ,
    .perf_beats (perf_beats)
`endif
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int checks;
  int failures;

  // Requester sources: remaining beats, beat index within packet, data base.
  int rem  [N];
  int beat [N];
  int base [N];
  logic r_en;

  // Adder model queue and transaction logs (one nibble per beat = one-hot bus).
  logic [W-1:0]  addq [$];
  logic [63:0]   acc_code;
  int            acc_n;
  logic [63:0]   res_code;
  int            res_n;
  logic [W-1:0]  res_last;
  logic [W-1:0]  res_sum;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_tvalid[i]            = (rem[i] != 0);
      s_tlast[i]             = (rem[i] == 1);
      s_tdata[i*CH*W +: CH*W] = {32'd1, 32'(base[i] + beat[i])};
    end
    r_tvalid = r_en && (addq.size() != 0);
    r_tdata  = (addq.size() != 0) ? addq[0] : '0;
  endtask

  task automatic clear_logs();
    acc_code = '0; acc_n = 0;
    res_code = '0; res_n = 0;
    res_last = '0; res_sum = '0;
  endtask

  task automatic start_pkt(input int r, input int len, input int b);
    rem[r]  = len;
    beat[r] = 0;
    base[r] = b;
  endtask

  // One clock: observe handshakes at the falling edge, update inputs after the rising edge.
  task automatic step();
    logic [N-1:0] fired;
    logic [W-1:0] tmp;
    @(negedge aclk);
    fired = s_tvalid & s_tready;
    if (a_tvalid && a_tready) begin
      addq.push_back(a_tdata[W-1:0] + a_tdata[2*W-1:W]);
      acc_n++;
      acc_code = (acc_code << 4) | 64'(s_tready);
    end
    if (r_tvalid && r_tready) begin
      tmp = addq.pop_front();
      res_n++;
      res_code = (res_code << 4) | 64'(m_tvalid);
      res_last = m_tdata;
      res_sum  = res_sum + m_tdata;
    end
    @(posedge aclk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (fired[i]) begin
        rem[i]--;
        beat[i]++;
      end
    end
    drive();
    #1;
  endtask

  function automatic bit sources_idle();
    for (int i = 0; i < N; i++) if (rem[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_until_done(input int max_cyc, input string tag);
    bit done;
    done = 1'b0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      step();
      done = sources_idle() && (addq.size() == 0) && !busy;
    end
    check(tag, 64'(done), 64'd1);
  endtask

  task automatic apply_reset();
    aresetn = 1'b0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    addq.delete();
    drive();
    step();
    step();
    aresetn = 1'b1;
    clear_logs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    aresetn  = 1'b0;
    a_tready = 1'b0;
    m_tready = '0;
    r_en     = 1'b0;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    r_tvalid = 1'b0;
    r_tdata  = '0;
    for (int i = 0; i < N; i++) begin rem[i] = 0; beat[i] = 0; base[i] = 0; end
    clear_logs();
    #3;
    // Reset state
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_a_tvalid", 64'(a_tvalid), 64'd0);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_r_tready", 64'(r_tready), 64'd0);
    check("rst_busy",     64'(busy),     64'd0);
    step();
    step();
    aresetn = 1'b1;
    clear_logs();

    // Requester 2 alone, 3 beats: results 11,12,13 on m_tvalid[2] only
    a_tready = 1'b1;
    r_en     = 1'b1;
    m_tready = '1;
    start_pkt(2, 3, 10);
    drive();
    #1;
    check("lat_no_offer_in_idle", 64'(a_tvalid), 64'd0);
    step();
    check("lat_first_offer", 64'(a_tvalid), 64'd1);
    check("grant_s_tready",  64'(s_tready), 64'h4);
    run_until_done(30, "r2_done");
    check("r2_accepts",  acc_code, 64'h444);
    check("r2_results",  res_code, 64'h444);
    check("r2_sum",      64'(res_sum),  64'd36);
    check("r2_last",     64'(res_last), 64'd13);

    // ptr is now 3: requesters 0 and 3 together -> 3 first, then 0
    clear_logs();
    start_pkt(0, 1, 0);
    start_pkt(3, 1, 0);
    drive();
    run_until_done(30, "ptr3_done");
    check("ptr3_order", acc_code, 64'h81);

    // From reset, requesters 0,1,3 with 2-beat packets -> 0,0,1,1,3,3
    apply_reset();
    start_pkt(0, 2, 0);
    start_pkt(1, 2, 20);
    start_pkt(3, 2, 40);
    drive();
    run_until_done(60, "rr3_done");
    check("rr3_accepts", acc_code, 64'h112288);
    check("rr3_results", res_code, 64'h112288);

    // Adder results stalled: tag FIFO caps issue at 8 beats
    apply_reset();
    r_en = 1'b0;
    start_pkt(0, 12, 0);
    drive();
    for (int c = 0; c < 20; c++) step();
    check("stall_issued",   64'(acc_n),    64'd8);
    check("stall_a_tvalid", 64'(a_tvalid), 64'd0);
    check("stall_busy",     64'(busy),     64'd1);
    r_en = 1'b1;
    drive();
    #1;
    check("stall_hold_prepop", 64'(a_tvalid), 64'd0);
    check("stall_r_tready",    64'(r_tready), 64'd1);
    step();
    check("stall_resume", 64'(a_tvalid), 64'd1);
    run_until_done(80, "stall_done");
    check("stall_total_acc", 64'(acc_n),    64'd12);
    check("stall_total_res", 64'(res_n),    64'd12);
    check("stall_last",      64'(res_last), 64'd12);

    // Head tag 1 with m_tready[1]=0: result 5 held, then delivered
    apply_reset();
    r_en     = 1'b1;
    m_tready = 4'b1101;
    start_pkt(1, 1, 4);
    drive();
    for (int c = 0; c < 6; c++) step();
    check("hold_r_tvalid", 64'(r_tvalid), 64'd1);
    check("hold_r_tready", 64'(r_tready), 64'd0);
    check("hold_m_tvalid", 64'(m_tvalid), 64'h2);
    check("hold_m_tdata",  64'(m_tdata),  64'd5);
    check("hold_no_pop",   64'(res_n),    64'd0);
    m_tready = '1;
    #1;
    check("rel_r_tready", 64'(r_tready), 64'd1);
    step();
    check("rel_results", res_code, 64'h2);
    check("rel_data",    64'(res_last), 64'd5);
    check("rel_busy",    64'(busy),     64'd0);

    // Reset after 2nd of 4 beats, then a fresh packet from requester 1
    apply_reset();
    start_pkt(2, 4, 0);
    drive();
    for (int c = 0; c < 20 && acc_n < 2; c++) step();
    check("mid_two_beats", 64'(acc_n), 64'd2);
    aresetn = 1'b0;
    #1;
    check("mid_rst_a_tvalid", 64'(a_tvalid), 64'd0);
    check("mid_rst_s_tready", 64'(s_tready), 64'd0);
    check("mid_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("mid_rst_r_tready", 64'(r_tready), 64'd0);
    check("mid_rst_busy",     64'(busy),     64'd0);
    apply_reset();
    start_pkt(1, 1, 7);
    drive();
    run_until_done(30, "post_rst_done");
    check("post_rst_accepts", acc_code, 64'h2);
    check("post_rst_results", res_code, 64'h2);
    check("post_rst_data",    64'(res_last), 64'd8);

`ifdef VADD_SCHED_PERF_EN
    apply_reset();
    start_pkt(0, 5, 0);
    drive();
    run_until_done(40, "perf_done");
    check("perf_req0",   64'(perf_beats[31:0]),   64'd5);
    check("perf_others", 64'(perf_beats[127:32]), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
